// File: rtl/dmem_responder.sv
// Single-port data-memory responder for a CPU data bus: captures one request,
// inserts WAIT_CYCLES wait states, then returns a one-cycle registered response.
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned AW          = 5
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_next;
    logic [AW+1:0]      r_addr;
    logic               r_we;
    logic [31:0]        r_wdata;
    logic [31:0]        r_mem [DEPTH];
    logic               r_ready;
    logic               r_err;
    logic [31:0]        r_rdata;

    logic               w_capture;
    logic               w_enter_resp;
    logic [AW+1:0]      w_wr_addr;
    logic               w_wr_we;
    logic [31:0]        w_wr_data;
    logic               w_wr_en;
    logic               w_resp_mis;
    logic [31:0]        w_rd_word;

    assign w_capture    = (r_state == ST_IDLE) && i_req;
    assign w_enter_resp = (w_state_next == ST_RESP) && (r_state != ST_RESP);
    assign w_resp_mis   = (r_addr[1:0] != 2'b00);
    assign w_rd_word    = r_mem[r_addr[AW+1:2]];

    // With zero wait states RESP is entered on the capture edge itself,
    // so the commit must use the live inputs rather than the captured copy.
    assign w_wr_addr = (r_state == ST_IDLE) ? i_addr[AW+1:0] : r_addr;
    assign w_wr_we   = (r_state == ST_IDLE) ? i_we           : r_we;
    assign w_wr_data = (r_state == ST_IDLE) ? i_wdata        : r_wdata;
    assign w_wr_en   = w_enter_resp && w_wr_we && (w_wr_addr[1:0] == 2'b00);

    // State and wait-counter registers
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_req) begin
                    w_state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    w_cnt_next   = CNT_LOAD;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request capture; only an IDLE request may update these
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
        end else if (w_capture) begin
            r_addr  <= i_addr[AW+1:0];
            r_we    <= i_we;
            r_wdata <= i_wdata;
        end
    end

    // Word array, cleared by reset, written on the edge entering RESP
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_wr_en) begin
            r_mem[w_wr_addr[AW+1:2]] <= w_wr_data;
        end
    end

    // Registered response: strobe appears in the cycle after RESP
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end else if (r_state == ST_RESP) begin
            r_ready <= 1'b1;
            r_err   <= w_resp_mis;
            r_rdata <= (!r_we && !w_resp_mis) ? w_rd_word : 32'd0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
        end
    end

    assign o_ready = r_ready;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with none, checked against hand-computed expected values.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, ready, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic        req0, we0, ready0, err0, busy0;
    logic [31:0] addr0, wdata0, rdata0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_responder #(.WAIT_CYCLES(2), .AW(5)) u_dut (
        .i_clock (clk),   .i_resetn (rst_n), .i_req   (req),   .i_we   (we),
        .i_addr  (addr),  .i_wdata  (wdata), .o_ready (ready), .o_rdata(rdata),
        .o_err   (err),   .o_busy   (busy)
    );

    dmem_responder #(.WAIT_CYCLES(0), .AW(5)) u_dut0 (
        .i_clock (clk),    .i_resetn (rst_n),  .i_req   (req0),   .i_we   (we0),
        .i_addr  (addr0),  .i_wdata  (wdata0), .o_ready (ready0), .o_rdata(rdata0),
        .o_err   (err0),   .o_busy   (busy0)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge. lat counts edges after the capture edge
    // until Ready is seen; inputs are scrambled after capture.
    task automatic xact(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                        input logic poke, output logic [31:0] rd, output logic er,
                        output int lat, output logic busy_seen);
        req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata;
        @(posedge clk);
        @(negedge clk);
        busy_seen = busy;
        req = 1'b0; we = ~t_we; addr = ~t_addr; wdata = ~t_wdata;
        lat = 0;
        while (!ready && lat < 20) begin
            if (poke && lat == 1) begin
                req = 1'b1; we = 1'b1; addr = 32'h0000_000C; wdata = 32'h5A5A_5A5A;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        req = 1'b0;
        rd  = rdata;
        er  = err;
    endtask

    logic [31:0] rd;
    logic        er, bs;
    int          lat, extra;

    initial begin
        rst_n = 1'b0;
        req = 1'b0;  we = 1'b0;  addr = 32'd0;  wdata = 32'd0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
        #12;
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_busy",  {31'd0, busy},  32'd0);
        check_val("rst_err",   {31'd0, err},   32'd0);
        check_val("rst_rdata", rdata,          32'd0);
        check_val("rst_ready0", {31'd0, ready0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // store then back-to-back load
        xact(1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, rd, er, lat, bs);
        check_val("st08_lat",  lat,           32'd3);
        check_val("st08_busy", {31'd0, bs},   32'd1);
        check_val("st08_busy_resp", {31'd0, busy}, 32'd0);
        check_val("st08_err",  {31'd0, er},   32'd0);
        check_val("st08_rd",   rd,            32'd0);
        xact(1'b0, 32'h08, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("ld08_lat",  lat,           32'd3);
        check_val("ld08_rd",   rd,            32'hDEAD_BEEF);
        check_val("ld08_err",  {31'd0, er},   32'd0);
        @(negedge clk);
        check_val("ld08_ready_drop", {31'd0, ready}, 32'd0);
        check_val("ld08_rd_drop",    rdata,          32'd0);

        // address wrap
        xact(1'b1, 32'h84, 32'h1234_5678, 1'b0, rd, er, lat, bs);
        xact(1'b0, 32'h04, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("wrap_rd", rd, 32'h1234_5678);

        // misaligned store and load
        xact(1'b1, 32'h0A, 32'hFFFF_FFFF, 1'b0, rd, er, lat, bs);
        check_val("mis_st_err", {31'd0, er}, 32'd1);
        check_val("mis_st_rd",  rd,          32'd0);
        xact(1'b0, 32'h09, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("mis_ld_err", {31'd0, er}, 32'd1);
        check_val("mis_ld_rd",  rd,          32'd0);
        xact(1'b0, 32'h08, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("mis_unch_rd", rd, 32'hDEAD_BEEF);

        // request during WAIT is ignored
        xact(1'b0, 32'h08, 32'h0, 1'b1, rd, er, lat, bs);
        check_val("ign_lat", lat, 32'd3);
        check_val("ign_rd",  rd,  32'hDEAD_BEEF);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) extra++;
        end
        check_val("ign_no_2nd_ready", extra, 32'd0);
        xact(1'b0, 32'h0C, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("ign_no_write", rd, 32'd0);

        // zero wait states, back-to-back
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; wdata0 = 32'h0BAD_F00D;
        @(posedge clk); @(negedge clk);
        req0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        check_val("w0_ready_k",  {31'd0, ready0}, 32'd0);
        check_val("w0_busy_k",   {31'd0, busy0},  32'd1);
        @(posedge clk); @(negedge clk);
        check_val("w0_ready_k1", {31'd0, ready0}, 32'd1);
        check_val("w0_err_k1",   {31'd0, err0},   32'd0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h14;
        @(posedge clk); @(negedge clk);
        req0 = 1'b0;
        check_val("w0_ready_k2", {31'd0, ready0}, 32'd0);
        @(posedge clk); @(negedge clk);
        check_val("w0_ready_k3", {31'd0, ready0}, 32'd1);
        check_val("w0_rd_k3",    rdata0,          32'h0BAD_F00D);

        // reset during WAIT aborts a store
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hAAAA_5555;
        @(posedge clk); @(negedge clk);
        req = 1'b0;
        check_val("rwait_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rwait_busy",  {31'd0, busy},  32'd0);
        check_val("rwait_ready", {31'd0, ready}, 32'd0);
        check_val("rwait_rdata", rdata,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("rwait_ld10_lat", lat, 32'd3);
        check_val("rwait_ld10_rd",  rd,  32'd0);
        xact(1'b0, 32'h08, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("rwait_mem_clr",  rd,  32'd0);

        // reset during the response cycle clears outputs without a clock edge
        xact(1'b1, 32'h04, 32'h1234_5678, 1'b0, rd, er, lat, bs);
        xact(1'b0, 32'h04, 32'h0, 1'b0, rd, er, lat, bs);
        check_val("rresp_rd_pre", rd, 32'h1234_5678);
        #2 rst_n = 1'b0;
        #1;
        check_val("rresp_ready", {31'd0, ready}, 32'd0);
        check_val("rresp_rdata", rdata,          32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
